// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 VGA timing constants, pattern mode encodings and the
// colour-bar index helper used by the timing generator and pattern source.
package vga_timing_pkg;

   localparam int unsigned DEPTH     = 3;
   localparam int unsigned CNT_W     = 10;
   localparam int unsigned CNT_MAX   = 1024;
   localparam int unsigned BAR_WIDTH = 80;

   localparam int unsigned H_VISIBLE = 640;
   localparam int unsigned H_FRONT   = 16;
   localparam int unsigned H_SYNC    = 96;
   localparam int unsigned H_BACK    = 48;
   localparam int unsigned H_TOTAL   = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
   localparam int unsigned H_SYNC_START = H_VISIBLE + H_FRONT;
   localparam int unsigned H_SYNC_END   = H_SYNC_START + H_SYNC - 1;

   localparam int unsigned V_VISIBLE = 480;
   localparam int unsigned V_FRONT   = 10;
   localparam int unsigned V_SYNC    = 2;
   localparam int unsigned V_BACK    = 33;
   localparam int unsigned V_TOTAL   = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
   localparam int unsigned V_SYNC_START = V_VISIBLE + V_FRONT;
   localparam int unsigned V_SYNC_END   = V_SYNC_START + V_SYNC - 1;

   typedef enum logic [1:0] {
      PAT_BARS  = 2'd0,
      PAT_GREEN = 2'd1,
      PAT_CHECK = 2'd2,
      PAT_GRAD  = 2'd3
   } pat_mode_e;

   // Eight vertical bars of BAR_WIDTH pixels across the visible line.
   function automatic logic [2:0] bar_index(input logic [9:0] h);
      return 3'(h / 10'(BAR_WIDTH));
   endfunction

endpackage

// File: rtl/video_pattern_gen.sv
// Combinational test-pattern source: maps the current counter position and
// the selected mode to the three colour channels (blanking applied upstream).
module video_pattern_gen
   import vga_timing_pkg::*;
#(
   parameter int C_depth = DEPTH
)(
   input  logic [9:0]         hcnt_i,
   input  logic [9:0]         vcnt_i,
   input  logic [1:0]         mode_i,
   output logic [C_depth-1:0] red_o,
   output logic [C_depth-1:0] green_o,
   output logic [C_depth-1:0] blue_o
);

   logic [2:0]         bar_s;
   logic               check_s;
   logic [C_depth-1:0] one_s;
   logic [C_depth+2:0] grad_ext_s;
   logic [C_depth-1:0] grad_s;
   logic               unused_vcnt_s;

   assign bar_s         = bar_index(hcnt_i);
   assign check_s       = hcnt_i[5] ^ vcnt_i[5];
   assign grad_ext_s    = {{C_depth{1'b0}}, hcnt_i[9:7]};
   assign grad_s        = grad_ext_s[C_depth-1:0];
   assign unused_vcnt_s = ^{vcnt_i[9:6], vcnt_i[4:0]};

   // Constant "1" at channel width, valid for any C_depth >= 1.
   always_comb begin
      one_s    = '0;
      one_s[0] = 1'b1;
   end

   // Per-mode colour selection.
   always_comb begin
      red_o   = '0;
      green_o = '0;
      blue_o  = '0;
      case (pat_mode_e'(mode_i))
         PAT_BARS: begin
            red_o   = {C_depth{bar_s[2]}};
            green_o = {C_depth{bar_s[1]}};
            blue_o  = {C_depth{bar_s[0]}};
         end
         PAT_GREEN: begin
            green_o = one_s;
         end
         PAT_CHECK: begin
            red_o   = {C_depth{check_s}};
            green_o = {C_depth{check_s}};
            blue_o  = {C_depth{check_s}};
         end
         PAT_GRAD: begin
            red_o   = grad_s;
            green_o = grad_s;
            blue_o  = grad_s;
         end
         default: begin
            red_o   = '0;
            green_o = '0;
            blue_o  = '0;
         end
      endcase
   end

endmodule

// File: rtl/vga_video_timing.sv
// VGA timing generator: pixel/line counters, sync/blank decode and a single
// output register stage so every output lags the counters by exactly one clock.
module vga_video_timing
   import vga_timing_pkg::*;
#(
   parameter int C_depth     = DEPTH,
   parameter int C_h_visible = H_VISIBLE,
   parameter int C_h_front   = H_FRONT,
   parameter int C_h_sync    = H_SYNC,
   parameter int C_h_back    = H_BACK,
   parameter int C_v_visible = V_VISIBLE,
   parameter int C_v_front   = V_FRONT,
   parameter int C_v_sync    = V_SYNC,
   parameter int C_v_back    = V_BACK,
   parameter int C_hsync_pol = 0,
   parameter int C_vsync_pol = 0
)(
   input  logic               clk_pixel,
   input  logic               reset,
   input  logic [1:0]         mode,
   output logic [C_depth-1:0] red_p,
   output logic [C_depth-1:0] green_p,
   output logic [C_depth-1:0] blue_p,
   output logic               hsync,
   output logic               vsync,
   output logic               blank,
   output logic [9:0]         x,
   output logic [9:0]         y,
   output logic               frame_start
);

   localparam int H_TOT = C_h_visible + C_h_front + C_h_sync + C_h_back;
   localparam int V_TOT = C_v_visible + C_v_front + C_v_sync + C_v_back;

   localparam logic [9:0] H_LAST     = 10'(H_TOT - 1);
   localparam logic [9:0] V_LAST     = 10'(V_TOT - 1);
   localparam logic [9:0] H_VIS      = 10'(C_h_visible);
   localparam logic [9:0] V_VIS      = 10'(C_v_visible);
   localparam logic [9:0] HS_START   = 10'(C_h_visible + C_h_front);
   localparam logic [9:0] HS_END     = 10'(C_h_visible + C_h_front + C_h_sync - 1);
   localparam logic [9:0] VS_START   = 10'(C_v_visible + C_v_front);
   localparam logic [9:0] VS_END     = 10'(C_v_visible + C_v_front + C_v_sync - 1);
   localparam logic       HS_ON      = (C_hsync_pol != 0) ? 1'b1 : 1'b0;
   localparam logic       VS_ON      = (C_vsync_pol != 0) ? 1'b1 : 1'b0;

   if ((H_TOT > CNT_MAX) || (V_TOT > CNT_MAX)) begin : g_bad_totals
      $error("vga_video_timing: H/V totals exceed the 10-bit counter range");
   end

   logic [9:0]         hcnt_q, hcnt_d;
   logic [9:0]         vcnt_q, vcnt_d;
   logic               h_vis_s, v_vis_s, vis_s;
   logic               h_sync_act_s, v_sync_act_s;
   logic [C_depth-1:0] red_s, green_s, blue_s;

   logic [C_depth-1:0] red_q, green_q, blue_q;
   logic               hsync_q, vsync_q, blank_q, frame_start_q;
   logic [9:0]         x_q, y_q;

   // Counter next-state: vcnt advances only on the hcnt wrap.
   always_comb begin
      hcnt_d = hcnt_q;
      vcnt_d = vcnt_q;
      if (hcnt_q == H_LAST) begin
         hcnt_d = 10'd0;
         if (vcnt_q == V_LAST) begin
            vcnt_d = 10'd0;
         end else begin
            vcnt_d = vcnt_q + 10'd1;
         end
      end else begin
         hcnt_d = hcnt_q + 10'd1;
      end
   end

   // Counter state register.
   always_ff @(posedge clk_pixel) begin
      if (reset) begin
         hcnt_q <= 10'd0;
         vcnt_q <= 10'd0;
      end else begin
         hcnt_q <= hcnt_d;
         vcnt_q <= vcnt_d;
      end
   end

   assign h_vis_s      = (hcnt_q < H_VIS);
   assign v_vis_s      = (vcnt_q < V_VIS);
   assign vis_s        = h_vis_s & v_vis_s;
   assign h_sync_act_s = (hcnt_q >= HS_START) && (hcnt_q <= HS_END);
   assign v_sync_act_s = (vcnt_q >= VS_START) && (vcnt_q <= VS_END);

   video_pattern_gen #(
      .C_depth (C_depth)
   ) u_pattern (
      .hcnt_i  (hcnt_q),
      .vcnt_i  (vcnt_q),
      .mode_i  (mode),
      .red_o   (red_s),
      .green_o (green_s),
      .blue_o  (blue_s)
   );

   // Output stage: all outputs describe the same counter position.
   always_ff @(posedge clk_pixel) begin
      if (reset) begin
         red_q         <= '0;
         green_q       <= '0;
         blue_q        <= '0;
         hsync_q       <= ~HS_ON;
         vsync_q       <= ~VS_ON;
         blank_q       <= 1'b1;
         x_q           <= 10'd0;
         y_q           <= 10'd0;
         frame_start_q <= 1'b0;
      end else begin
         red_q         <= vis_s ? red_s   : '0;
         green_q       <= vis_s ? green_s : '0;
         blue_q        <= vis_s ? blue_s  : '0;
         hsync_q       <= h_sync_act_s ? HS_ON : ~HS_ON;
         vsync_q       <= v_sync_act_s ? VS_ON : ~VS_ON;
         blank_q       <= ~vis_s;
         x_q           <= hcnt_q;
         y_q           <= vcnt_q;
         frame_start_q <= (hcnt_q == 10'd0) && (vcnt_q == 10'd0);
      end
   end

   assign red_p       = red_q;
   assign green_p     = green_q;
   assign blue_p      = blue_q;
   assign hsync       = hsync_q;
   assign vsync       = vsync_q;
   assign blank       = blank_q;
   assign x           = x_q;
   assign y           = y_q;
   assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_video_timing.sv
// Directed bench: full-size 640x480 instance for line/pattern/reset behaviour,
// plus a shrunken-geometry instance so a whole frame fits in a short run.
module tb_vga_video_timing;

   logic       clk_pixel;
   logic       reset, reset_s;
   logic [1:0] mode;

   logic [2:0] red_p, green_p, blue_p;
   logic       hsync, vsync, blank, frame_start;
   logic [9:0] x, y;

   logic [2:0] s_red, s_green, s_blue;
   logic       s_hsync, s_vsync, s_blank, s_frame_start;
   logic [9:0] s_x, s_y;

   int n_checks = 0;
   int n_pass   = 0;

   vga_video_timing dut (
      .clk_pixel   (clk_pixel),
      .reset       (reset),
      .mode        (mode),
      .red_p       (red_p),
      .green_p     (green_p),
      .blue_p      (blue_p),
      .hsync       (hsync),
      .vsync       (vsync),
      .blank       (blank),
      .x           (x),
      .y           (y),
      .frame_start (frame_start)
   );

   // 80 pixels x 58 lines: visible 64x48, vsync on lines 51..52.
   vga_video_timing #(
      .C_h_visible (64), .C_h_front (4), .C_h_sync (8), .C_h_back (4),
      .C_v_visible (48), .C_v_front (3), .C_v_sync (2), .C_v_back (5)
   ) dut_small (
      .clk_pixel   (clk_pixel),
      .reset       (reset_s),
      .mode        (mode),
      .red_p       (s_red),
      .green_p     (s_green),
      .blue_p      (s_blue),
      .hsync       (s_hsync),
      .vsync       (s_vsync),
      .blank       (s_blank),
      .x           (s_x),
      .y           (s_y),
      .frame_start (s_frame_start)
   );

   initial clk_pixel = 1'b0;
   always #5 clk_pixel = ~clk_pixel;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end else begin
         n_pass++;
      end
   endtask

   task automatic step();
      @(posedge clk_pixel);
      #1;
   endtask

   function automatic logic [8:0] rgb();
      return {red_p, green_p, blue_p};
   endfunction

   task automatic wait_xy(input int wx, input int wy, input int budget);
      int n = 0;
      while (!((x == 10'(wx)) && (y == 10'(wy))) && (n < budget)) begin
         step();
         n++;
      end
      check_val($sformatf("reach_%0d_%0d", wx, wy),
                32'((x == 10'(wx)) && (y == 10'(wy))), 32'd1);
   endtask

   initial begin
      int hs_low, hs_first, blank_hi, blank_err, x_err;
      int vs_low, vs_first, vs_first_y, fs_cnt, vblank_err;

      reset   = 1'b1;
      reset_s = 1'b1;
      mode    = 2'd0;
      repeat (5) step();
      check_val("rst_x",     32'(x), 32'd0);
      check_val("rst_y",     32'(y), 32'd0);
      check_val("rst_blank", 32'(blank), 32'd1);
      check_val("rst_rgb",   32'(rgb()), 32'd0);
      check_val("rst_fs",    32'(frame_start), 32'd0);
      check_val("rst_hs",    32'(hsync), 32'd1);
      check_val("rst_vs",    32'(vsync), 32'd1);

      reset = 1'b0;
      step();
      check_val("first_x",     32'(x), 32'd0);
      check_val("first_y",     32'(y), 32'd0);
      check_val("first_blank", 32'(blank), 32'd0);
      check_val("first_fs",    32'(frame_start), 32'd1);
      check_val("first_hs",    32'(hsync), 32'd1);
      check_val("first_vs",    32'(vsync), 32'd1);

      // One full line of the 640x480 instance.
      hs_low = 0; hs_first = -1; blank_hi = 0; blank_err = 0; x_err = 0;
      for (int k = 0; k < 800; k++) begin
         if (x !== 10'(k)) x_err++;
         if (hsync === 1'b0) begin
            if (hs_first < 0) hs_first = k;
            hs_low++;
         end
         if (blank === 1'b1) blank_hi++;
         if (blank !== (k >= 640)) blank_err++;
         step();
      end
      check_val("line_x_seq",     32'(x_err), 32'd0);
      check_val("line_hs_len",    32'(hs_low), 32'd96);
      check_val("line_hs_start",  32'(hs_first), 32'd656);
      check_val("line_blank_len", 32'(blank_hi), 32'd160);
      check_val("line_blank_pos", 32'(blank_err), 32'd0);
      check_val("line_wrap_x",    32'(x), 32'd0);
      check_val("line_wrap_y",    32'(y), 32'd1);
      check_val("line_wrap_fs",   32'(frame_start), 32'd0);

      // Colour bars (mode 0)
      check_val("bar_x0",   32'(rgb()), 32'o000);
      wait_xy(79, 1, 100);
      check_val("bar_x79",  32'(rgb()), 32'o000);
      wait_xy(80, 1, 10);
      check_val("bar_x80",  32'(rgb()), 32'o007);
      wait_xy(160, 1, 100);
      check_val("bar_x160", 32'(rgb()), 32'o070);
      wait_xy(559, 1, 500);
      check_val("bar_x559", 32'(rgb()), 32'o770);
      wait_xy(560, 1, 10);
      check_val("bar_x560", 32'(rgb()), 32'o777);
      wait_xy(639, 1, 100);
      check_val("bar_x639", 32'(rgb()), 32'o777);
      wait_xy(640, 1, 10);
      check_val("bar_x640", 32'(rgb()), 32'o000);
      check_val("bar_x640_blank", 32'(blank), 32'd1);

      // Checkerboard (mode 2): colour = hcnt[5] ^ vcnt[5]
      mode = 2'd2;
      wait_xy(31, 2, 1000);
      check_val("chk_31_2", 32'(rgb()), 32'o000);
      wait_xy(32, 2, 10);
      check_val("chk_32_2", 32'(rgb()), 32'o777);
      wait_xy(64, 2, 100);
      check_val("chk_64_2", 32'(rgb()), 32'o000);
      wait_xy(32, 32, 30000);
      check_val("chk_32_32", 32'(rgb()), 32'o000);
      wait_xy(64, 32, 100);
      check_val("chk_64_32", 32'(rgb()), 32'o777);

      // Mid-line switch to solid green
      wait_xy(200, 33, 2000);
      check_val("sw_pre_rgb", 32'(rgb()), 32'o777);
      check_val("sw_pre_hs",  32'(hsync), 32'd1);
      mode = 2'd1;
      step();
      check_val("sw_x",       32'(x), 32'd201);
      check_val("sw_rgb",     32'(rgb()), 32'o010);
      check_val("sw_hs",      32'(hsync), 32'd1);
      wait_xy(655, 33, 1000);
      check_val("sw_hs_655",  32'(hsync), 32'd1);
      wait_xy(656, 33, 10);
      check_val("sw_hs_656",  32'(hsync), 32'd0);
      wait_xy(751, 33, 200);
      check_val("sw_hs_751",  32'(hsync), 32'd0);
      wait_xy(752, 33, 10);
      check_val("sw_hs_752",  32'(hsync), 32'd1);

      // Reset in the middle of a visible line
      wait_xy(300, 34, 1000);
      reset = 1'b1;
      step();
      check_val("mid_x",     32'(x), 32'd0);
      check_val("mid_y",     32'(y), 32'd0);
      check_val("mid_blank", 32'(blank), 32'd1);
      check_val("mid_rgb",   32'(rgb()), 32'd0);
      check_val("mid_hs",    32'(hsync), 32'd1);
      check_val("mid_vs",    32'(vsync), 32'd1);
      check_val("mid_fs",    32'(frame_start), 32'd0);
      step();
      reset = 1'b0;
      step();
      check_val("rs_x",     32'(x), 32'd0);
      check_val("rs_y",     32'(y), 32'd0);
      check_val("rs_blank", 32'(blank), 32'd0);
      check_val("rs_fs",    32'(frame_start), 32'd1);
      check_val("rs_rgb",   32'(rgb()), 32'o010);
      step();
      check_val("rs2_x",    32'(x), 32'd1);
      check_val("rs2_fs",   32'(frame_start), 32'd0);

      // Whole frame on the small-geometry instance
      mode = 2'd0;
      reset_s = 1'b0;
      step();
      check_val("s_first_fs",  32'(s_frame_start), 32'd1);
      check_val("s_first_rgb", 32'({s_red, s_green, s_blue}), 32'd0);
      vs_low = 0; vs_first = -1; vs_first_y = -1; blank_hi = 0; fs_cnt = 0; vblank_err = 0;
      for (int k = 0; k < 4640; k++) begin
         if (s_vsync === 1'b0) begin
            if (vs_first < 0) begin
               vs_first   = k;
               vs_first_y = int'(s_y);
            end
            vs_low++;
         end
         if (s_blank === 1'b1) blank_hi++;
         if ((s_y >= 10'd48) && (s_blank !== 1'b1)) vblank_err++;
         if (s_frame_start === 1'b1) fs_cnt++;
         step();
      end
      check_val("s_vs_len",     32'(vs_low), 32'd160);
      check_val("s_vs_start",   32'(vs_first), 32'd4080);
      check_val("s_vs_line",    32'(vs_first_y), 32'd51);
      check_val("s_blank_len",  32'(blank_hi), 32'd1568);
      check_val("s_vblank",     32'(vblank_err), 32'd0);
      check_val("s_fs_count",   32'(fs_cnt), 32'd1);
      check_val("s_period_fs",  32'(s_frame_start), 32'd1);
      check_val("s_period_x",   32'(s_x), 32'd0);
      check_val("s_period_y",   32'(s_y), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
